// File: rtl/code_loader_if.sv
// Memory-side bus of the boot loader: write handshake plus optional
// read-back path. The loader drives the master side; the memory is the slave.
interface code_loader_if #(
  parameter int ADDR_W = 8
);
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wr_data;
  logic              mem_wr_ack;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_data;
  logic              mem_rd_valid;

  modport master (
    output mem_wr_en, mem_addr, mem_wr_data, mem_rd_en,
    input  mem_wr_ack, mem_rd_data, mem_rd_valid
  );

  modport slave (
    input  mem_wr_en, mem_addr, mem_wr_data, mem_rd_en,
    output mem_wr_ack, mem_rd_data, mem_rd_valid
  );
endinterface

// File: rtl/code_loader.sv
// Boot-time sequencer: copies `length` bytes of the program image into the
// computer's memory through a write handshake while holding the CPU in reset,
// then releases the CPU.
// Optional feature macro: LOADER_VERIFY_EN adds a read-back of every byte and
// a sticky `error` flag; without it `mem_rd_en` and `error` are constant 0.
module code_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8*DEPTH-1:0] code,
  input  logic               start,
  input  logic [ADDR_W:0]    length,
  code_loader_if.master      bus,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  state_t          state;
  // One bit wider than the address so a full-depth load ends without wrapping.
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] nxt;
  logic [ADDR_W:0] req_len;

  function automatic logic [7:0] byte_at(input logic [8*DEPTH-1:0] img,
                                         input logic [ADDR_W-1:0]  idx);
    return img[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] n);
    return (n > FULL) ? FULL : n;
  endfunction

  assign nxt     = cnt + 1'b1;
  assign req_len = clamp_len(length);

`ifndef LOADER_VERIFY_EN
  logic unused_rd;
  assign unused_rd     = ^{bus.mem_rd_data, bus.mem_rd_valid};
  assign bus.mem_rd_en = 1'b0;
  assign error         = 1'b0;
`endif

  // Load sequencer: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      len             <= '0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      cpu_hold        <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef LOADER_VERIFY_EN
      bus.mem_rd_en   <= 1'b0;
      error           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len             <= req_len;
            cnt             <= '0;
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= byte_at(code, '0);
`ifdef LOADER_VERIFY_EN
            error           <= 1'b0;
`endif
            if (req_len == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state         <= WRITE;
              bus.mem_wr_en <= 1'b1;
              busy          <= 1'b1;
              done          <= 1'b0;
              cpu_hold      <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.mem_wr_ack) begin
`ifdef LOADER_VERIFY_EN
            bus.mem_wr_en <= 1'b0;
            bus.mem_rd_en <= 1'b1;
            state         <= VERIFY;
          end
        end
        VERIFY: begin
          if (bus.mem_rd_valid) begin
            // mem_wr_data still holds the byte just written.
            if (bus.mem_rd_data != bus.mem_wr_data) error <= 1'b1;
            bus.mem_rd_en <= 1'b0;
`endif
            // Advance to the next byte, or finish after the last one.
            if (nxt == len) begin
              state         <= DONE;
              bus.mem_wr_en <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              cpu_hold      <= 1'b0;
            end else begin
              state           <= WRITE;
              cnt             <= nxt;
              bus.mem_wr_en   <= 1'b1;
              bus.mem_addr    <= nxt[ADDR_W-1:0];
              bus.mem_wr_data <= byte_at(code, nxt[ADDR_W-1:0]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: a byte-level reference model of the
// load sequence, a memory model with optional readback corruption at addr 5,
// directed scenarios with literal expectations and a randomized phase.
module tb_code_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
`ifdef LOADER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam logic [15:0] EXP1 [4] = '{16'h0001, 16'h0101, 16'h0244, 16'h0301};

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [8*DEPTH-1:0] code = '0;
  logic [ADDR_W:0]    length = '0;
  logic               cpu_hold, busy, done, error;

  code_loader_if #(.ADDR_W(ADDR_W)) bus();

  code_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .code(code), .start(start), .length(length),
    .bus(bus), .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit chk_on = 1'b0;
  int ack_mode = 0;   // 0: ack/valid tied high, 1: random, 2: stall byte 2
  int stall_n = 0;
  bit corrupt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory model and write log.
  logic [7:0]  mem [DEPTH];
  logic [15:0] wlog [$];
  always @(posedge clk)
    if (bus.mem_wr_en && bus.mem_wr_ack) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
      wlog.push_back({bus.mem_addr, bus.mem_wr_data});
    end
  assign bus.mem_rd_data = mem[bus.mem_addr] ^ ((corrupt && bus.mem_addr == 8'd5) ? 8'h5A : 8'h00);

  // Memory-side handshake driver.
  initial begin
    bus.mem_wr_ack = 1'b0;
    bus.mem_rd_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_mode == 1) begin
        bus.mem_wr_ack   = ($urandom_range(0, 2) != 0);
        bus.mem_rd_valid = ($urandom_range(0, 1) == 1);
      end else if (ack_mode == 2 && bus.mem_wr_en && bus.mem_addr == 8'd2 && stall_n < 3) begin
        bus.mem_wr_ack   = 1'b0;
        bus.mem_rd_valid = 1'b1;
        stall_n++;
      end else begin
        bus.mem_wr_ack   = 1'b1;
        bus.mem_rd_valid = 1'b1;
      end
    end
  end

  function automatic int clamp_l(input logic [ADDR_W:0] n);
    return (n > 9'd256) ? 256 : int'(n);
  endfunction

  // Reference model: which byte is in flight, whether it is being read back,
  // and whether a load is running or has finished.
  logic m_busy, m_done, m_ph, m_err;
  int   m_idx, m_len;
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_ph <= 1'b0; m_err <= 1'b0; m_idx <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_len  <= clamp_l(length);
        m_idx  <= 0;
        m_ph   <= 1'b0;
        m_err  <= 1'b0;
        m_busy <= (clamp_l(length) != 0);
        m_done <= (clamp_l(length) == 0);
      end
    end else if (!m_ph) begin
      if (bus.mem_wr_ack) begin
        if (VER) m_ph <= 1'b1;
        else if (m_idx + 1 == m_len) begin m_busy <= 1'b0; m_done <= 1'b1; end
        else m_idx <= m_idx + 1;
      end
    end else if (bus.mem_rd_valid) begin
      if (bus.mem_rd_data != code[8*m_idx +: 8]) m_err <= 1'b1;
      m_ph <= 1'b0;
      if (m_idx + 1 == m_len) begin m_busy <= 1'b0; m_done <= 1'b1; end
      else m_idx <= m_idx + 1;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("cpu_hold", cpu_hold, !m_done);
      chk("wr_en", bus.mem_wr_en, m_busy && !m_ph);
      chk("rd_en", bus.mem_rd_en, m_busy && m_ph);
      chk("error", error, m_err);
      if (m_busy) begin
        chk("addr", bus.mem_addr, m_idx[7:0]);
        if (!m_ph) chk("wr_data", bus.mem_wr_data, code[8*m_idx +: 8]);
      end
    end
  end

  function automatic int log_bad(input int n);
    int bad = 0;
    if (wlog.size() != n) bad++;
    for (int i = 0; i < wlog.size() && i < n; i++)
      if (wlog[i] !== {i[7:0], code[8*i +: 8]}) bad++;
    return bad;
  endfunction

  task automatic do_load(input int len, input int budget, input int pulse_at,
                         output int cyc, output logic hold1, output logic err1);
    @(negedge clk);
    wlog.delete();
    start  = 1'b1;
    length = len[ADDR_W:0];
    cyc    = 0;
    hold1  = 1'b0;
    err1   = 1'b0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin hold1 = cpu_hold; err1 = error; end
      start = (cyc == pulse_at) && busy;
      if (start) length = 9'd5;
    end while (!done && cyc < budget);
    chk("load_done", done, 1'b1);
  endtask

  task automatic rand_code();
    for (int i = 0; i < DEPTH; i++) code[8*i +: 8] = 8'($urandom);
  endtask

  int   cyc, k, rl;
  logic h, e;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cpu_hold", cpu_hold, 1'b1);
    chk("rst_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst_rd_en", bus.mem_rd_en, 1'b0);
    chk("rst_addr", bus.mem_addr, 8'h00);
    chk("rst_wr_data", bus.mem_wr_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    reset  = 1'b0;
    chk_on = 1'b1;

    // Four-byte image with ack tied high.
    code = '0;
    code[7:0] = 8'h01; code[15:8] = 8'h01; code[23:16] = 8'h44; code[31:24] = 8'h01;
    do_load(4, 50, 0, cyc, h, e);
    chk("t1_latency", cyc, VER ? 9 : 5);
    chk("t1_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_write", wlog[i], EXP1[i]);
    chk("t1_cpu_hold", cpu_hold, 1'b0);

    // Ack stalled three cycles on byte 2.
    ack_mode = 2; stall_n = 0;
    do_load(4, 50, 0, cyc, h, e);
    chk("t2_latency", cyc, VER ? 12 : 8);
    chk("t2_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_write", wlog[i], EXP1[i]);
    chk("t2_stalls", stall_n, 3);
    ack_mode = 0;

    // Full-depth load, zero-length load, over-length request.
    rand_code();
    do_load(256, 1200, 0, cyc, h, e);
    chk("t3_latency", cyc, VER ? 513 : 257);
    chk("t3_last_addr", wlog[255][15:8], 8'hFF);
    chk("t3_log", log_bad(256), 0);
    do_load(0, 10, 0, cyc, h, e);
    chk("t3_len0_latency", cyc, 1);
    chk("t3_len0_nwrites", wlog.size(), 0);
    do_load(300, 1200, 0, cyc, h, e);
    chk("t3_clamp_latency", cyc, VER ? 513 : 257);
    chk("t3_clamp_log", log_bad(256), 0);

    // Reset in the middle of byte 10, then reload.
    @(negedge clk); start = 1'b1; length = 9'd20;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(bus.mem_wr_en && bus.mem_addr == 8'd10) && k < 60) begin @(negedge clk); k++; end
    chk("t4_reach_byte10", bus.mem_addr, 8'd10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_busy", busy, 1'b0);
    chk("t4_cpu_hold", cpu_hold, 1'b1);
    chk("t4_wr_en", bus.mem_wr_en, 1'b0);
    do_load(20, 200, 0, cyc, h, e);
    chk("t4_latency", cyc, VER ? 41 : 21);
    chk("t4_first_addr", wlog[0][15:8], 8'h00);
    chk("t4_log", log_bad(20), 0);

    // Start while busy is ignored; start in DONE reloads.
    ack_mode = 1;
    do_load(30, 600, 6, cyc, h, e);
    chk("t5_log_busy_start", log_bad(30), 0);
    do_load(3, 100, 0, cyc, h, e);
    chk("t5_hold_on_restart", h, 1'b1);
    chk("t5_log_restart", log_bad(3), 0);

    // Readback corruption at addr 5.
    corrupt = 1'b1;
    do_load(8, 200, 0, cyc, h, e);
    chk("t6_error", error, VER);
    corrupt = 1'b0;
    do_load(3, 100, 0, cyc, h, e);
    chk("t6_error_cleared", e, 1'b0);
    chk("t6_error_final", error, 1'b0);

    // Randomized loads.
    for (int it = 0; it < 25; it++) begin
      rand_code();
      corrupt = 1'($urandom_range(0, 1));
      rl = (it < 3) ? $urandom_range(200, 511) : $urandom_range(0, 40);
      do_load(rl, 4000, $urandom_range(2, 15), cyc, h, e);
      chk("rand_log", log_bad(clamp_l(rl[ADDR_W:0])), 0);
      chk("rand_error", error, VER && corrupt && clamp_l(rl[ADDR_W:0]) > 5);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
